// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_WB_SRC = 4;
  // Tag field of the shared request type; instances use TAG_WIDTH <= WB_TAG_MAX.
  localparam int unsigned WB_TAG_MAX = 32;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MUL = 2'd1,
    WB_SRC_DIV = 2'd2,
    WB_SRC_LSU = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rd_addr;
    logic [XLEN-1:0]       data;
    logic [WB_TAG_MAX-1:0] tag;
  } wb_req_t;

  // One-hot destination bit; x0 never counts as a pending write.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd, input logic en);
    logic [31:0] m;
    m = '0;
    if (en && (rd != 5'd0)) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/dff_rst_en.sv
// Enabled register with asynchronous active-low clear.
module dff_rst_en #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when enabled; clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/wb_arbiter_grant_arb.sv
// One-hot grant over the four writeback buffers.
// WB_ARB_RR_EN defined: round-robin starting from a pointer (reset = ALU).
// Otherwise: fixed priority LSU > DIV > MUL > ALU.
module wb_grant_arb
  import wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_WB_SRC-1:0] req,
  output logic [NUM_WB_SRC-1:0] grant
);

`ifdef WB_ARB_RR_EN
  wb_src_e    ptr, ptr_d;
  logic [1:0] idx;

  // Pointer names the highest-priority source; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= WB_SRC_ALU;
    else        ptr <= ptr_d;
  end

  // Scan from the pointer upward (mod 4); first requester wins.
  always_comb begin
    grant = '0;
    ptr_d = ptr;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_WB_SRC; k++) begin
      idx = ptr + 2'(k);
      if ((grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        ptr_d      = wb_src_e'(idx + 2'd1);
      end
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Long-latency units drain first.
  always_comb begin
    grant = '0;
    if      (req[WB_SRC_LSU]) grant[WB_SRC_LSU] = 1'b1;
    else if (req[WB_SRC_DIV]) grant[WB_SRC_DIV] = 1'b1;
    else if (req[WB_SRC_MUL]) grant[WB_SRC_MUL] = 1'b1;
    else if (req[WB_SRC_ALU]) grant[WB_SRC_ALU] = 1'b1;
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: four one-entry source buffers share the reg_file write
// port. Arbitration mode selected by WB_ARB_RR_EN (see wb_grant_arb).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_wb_valid,
  input  logic [4:0]           alu_wb_rd_addr,
  input  logic [XLEN-1:0]      alu_wb_data,
  input  logic [TAG_WIDTH-1:0] alu_wb_tag,
  output logic                 alu_wb_ready,
  input  logic                 mul_wb_valid,
  input  logic [4:0]           mul_wb_rd_addr,
  input  logic [XLEN-1:0]      mul_wb_data,
  input  logic [TAG_WIDTH-1:0] mul_wb_tag,
  output logic                 mul_wb_ready,
  input  logic                 div_wb_valid,
  input  logic [4:0]           div_wb_rd_addr,
  input  logic [XLEN-1:0]      div_wb_data,
  input  logic [TAG_WIDTH-1:0] div_wb_tag,
  output logic                 div_wb_ready,
  input  logic                 lsu_wb_valid,
  input  logic [4:0]           lsu_wb_rd_addr,
  input  logic [XLEN-1:0]      lsu_wb_data,
  input  logic [TAG_WIDTH-1:0] lsu_wb_tag,
  output logic                 lsu_wb_ready,
  output logic                 exu_wb_rd_wr_en,
  output logic [4:0]           exu_wb_rd_addr,
  output logic [XLEN-1:0]      exu_wb_data,
  output logic [TAG_WIDTH-1:0] exu_wb_tag,
  output logic [31:0]          wb_pending_mask,
  output logic                 wb_busy
);

  wb_req_t                in_req [NUM_WB_SRC];
  wb_req_t                buf_q  [NUM_WB_SRC];
  wb_req_t                g_req;
  logic [NUM_WB_SRC-1:0]  req;
  logic [NUM_WB_SRC-1:0]  grant;
  logic [NUM_WB_SRC-1:0]  ready;
  logic [NUM_WB_SRC-1:0]  load;
  logic                   any_grant;
  logic                   unused_greq;

  assign in_req[WB_SRC_ALU] = '{valid: alu_wb_valid, rd_addr: alu_wb_rd_addr,
                                data: alu_wb_data, tag: WB_TAG_MAX'(alu_wb_tag)};
  assign in_req[WB_SRC_MUL] = '{valid: mul_wb_valid, rd_addr: mul_wb_rd_addr,
                                data: mul_wb_data, tag: WB_TAG_MAX'(mul_wb_tag)};
  assign in_req[WB_SRC_DIV] = '{valid: div_wb_valid, rd_addr: div_wb_rd_addr,
                                data: div_wb_data, tag: WB_TAG_MAX'(div_wb_tag)};
  assign in_req[WB_SRC_LSU] = '{valid: lsu_wb_valid, rd_addr: lsu_wb_rd_addr,
                                data: lsu_wb_data, tag: WB_TAG_MAX'(lsu_wb_tag)};

  for (genvar s = 0; s < NUM_WB_SRC; s++) begin : g_src
    wb_req_t buf_d;
    logic    buf_en;

    assign req[s]   = buf_q[s].valid;
    assign ready[s] = ~buf_q[s].valid | grant[s];
    // rd = x0 completes the handshake but never occupies the buffer.
    assign load[s]  = in_req[s].valid & ready[s] & (in_req[s].rd_addr != 5'd0);
    assign buf_en   = load[s] | grant[s];

    // Reload wins over the grant-clear when both happen in one cycle.
    always_comb begin
      buf_d       = buf_q[s];
      buf_d.valid = 1'b0;
      if (load[s]) buf_d = in_req[s];
    end

    dff_rst_en #(.WIDTH($bits(wb_req_t))) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (buf_en),
      .d     (buf_d),
      .q     (buf_q[s])
    );
  end

  wb_grant_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant)
  );

  assign alu_wb_ready = ready[WB_SRC_ALU];
  assign mul_wb_ready = ready[WB_SRC_MUL];
  assign div_wb_ready = ready[WB_SRC_DIV];
  assign lsu_wb_ready = ready[WB_SRC_LSU];
  assign any_grant    = |grant;
  assign wb_busy      = |req;

  // Select the granted buffer (grant is one-hot).
  always_comb begin
    g_req = '0;
    for (int unsigned s = 0; s < NUM_WB_SRC; s++) begin
      if (grant[s]) g_req = buf_q[s];
    end
  end

  assign unused_greq = g_req.valid ^ (^g_req.tag);

  // Write-port register: pulse enable on grant, hold address/data/tag otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exu_wb_rd_wr_en <= 1'b0;
      exu_wb_rd_addr  <= '0;
      exu_wb_data     <= '0;
      exu_wb_tag      <= '0;
    end else begin
      exu_wb_rd_wr_en <= any_grant;
      if (any_grant) begin
        exu_wb_rd_addr <= g_req.rd_addr;
        exu_wb_data    <= g_req.data;
        exu_wb_tag     <= g_req.tag[TAG_WIDTH-1:0];
      end
    end
  end

  // Destinations still owed a write: every held buffer plus the write in flight.
  always_comb begin
    wb_pending_mask = rd_onehot(exu_wb_rd_addr, exu_wb_rd_wr_en);
    for (int unsigned s = 0; s < NUM_WB_SRC; s++) begin
      wb_pending_mask = wb_pending_mask | rd_onehot(buf_q[s].rd_addr, buf_q[s].valid);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level model.
module tb_wb_arbiter;

  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_v    [4];
  logic [4:0]  in_rd   [4];
  logic [31:0] in_data [4];
  logic [TW-1:0] in_tag [4];
  logic [3:0]  rdy;
  logic        exu_en;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic [TW-1:0] exu_tag;
  logic [31:0] mask;
  logic        busy;

  wb_arbiter #(.TAG_WIDTH(TW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_wb_valid    (in_v[0]), .alu_wb_rd_addr (in_rd[0]), .alu_wb_data (in_data[0]),
    .alu_wb_tag      (in_tag[0]), .alu_wb_ready (rdy[0]),
    .mul_wb_valid    (in_v[1]), .mul_wb_rd_addr (in_rd[1]), .mul_wb_data (in_data[1]),
    .mul_wb_tag      (in_tag[1]), .mul_wb_ready (rdy[1]),
    .div_wb_valid    (in_v[2]), .div_wb_rd_addr (in_rd[2]), .div_wb_data (in_data[2]),
    .div_wb_tag      (in_tag[2]), .div_wb_ready (rdy[2]),
    .lsu_wb_valid    (in_v[3]), .lsu_wb_rd_addr (in_rd[3]), .lsu_wb_data (in_data[3]),
    .lsu_wb_tag      (in_tag[3]), .lsu_wb_ready (rdy[3]),
    .exu_wb_rd_wr_en (exu_en),
    .exu_wb_rd_addr  (exu_rd),
    .exu_wb_data     (exu_data),
    .exu_wb_tag      (exu_tag),
    .wb_pending_mask (mask),
    .wb_busy         (busy)
  );

  // Reference model: pending results per source and the write port.
  bit          mb_v    [4];
  logic [4:0]  mb_rd   [4];
  logic [31:0] mb_data [4];
  logic [TW-1:0] mb_tag [4];
  bit          mo_en;
  logic [4:0]  mo_rd;
  logic [31:0] mo_data;
  logic [TW-1:0] mo_tag;
  int          ptr;
  bit          acc [4];

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  bit mul_drop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      mb_v[s] = 0; mb_rd[s] = '0; mb_data[s] = '0; mb_tag[s] = '0; acc[s] = 0;
    end
    mo_en = 0; mo_rd = '0; mo_data = '0; mo_tag = '0; ptr = 0;
  endtask

  // Which source writes back this cycle, or -1.
  function automatic int pick();
    int s;
    for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_RR_EN
      s = (ptr + k) % 4;
`else
      s = 3 - k;
`endif
      if (mb_v[s]) return s;
    end
    return -1;
  endfunction

  // Check the DUT against the model at the negedge, then advance the model
  // over the coming rising edge and return 1 time unit after it.
  task automatic step();
    int g;
    bit er [4];
    logic [31:0] em;
    @(negedge clk);
    g  = pick();
    em = '0;
    for (int s = 0; s < 4; s++) begin
      er[s] = !mb_v[s] || (g == s);
      chk($sformatf("ready[%0d]", s), 64'(rdy[s]), 64'(er[s]));
      if (mb_v[s] && mb_rd[s] != 0) em[mb_rd[s]] = 1'b1;
    end
    if (mo_en && mo_rd != 0) em[mo_rd] = 1'b1;
    chk("busy", 64'(busy), 64'(mb_v[0] | mb_v[1] | mb_v[2] | mb_v[3]));
    chk("mask", 64'(mask), 64'(em));
    chk("wr_en", 64'(exu_en), 64'(mo_en));
    chk("wr_rd", 64'(exu_rd), 64'(mo_rd));
    chk("wr_data", 64'(exu_data), 64'(mo_data));
    chk("wr_tag", 64'(exu_tag), 64'(mo_tag));
    if (exu_en === 1'b1) pulses++;
    if (rdy[1] !== 1'b1) mul_drop = 1;
    if (g >= 0) begin
      mo_en = 1; mo_rd = mb_rd[g]; mo_data = mb_data[g]; mo_tag = mb_tag[g];
      mb_v[g] = 0;
      ptr = (g + 1) % 4;
    end else begin
      mo_en = 0;
    end
    for (int s = 0; s < 4; s++) begin
      acc[s] = in_v[s] && er[s];
      if (acc[s] && in_rd[s] != 0) begin
        mb_v[s] = 1; mb_rd[s] = in_rd[s]; mb_data[s] = in_data[s]; mb_tag[s] = in_tag[s];
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Withdraw each request once it has been taken, then run n cycles.
  task automatic drain(input int n);
    repeat (n) begin
      for (int s = 0; s < 4; s++) if (acc[s]) in_v[s] = 0;
      step();
    end
  endtask

  task automatic drive(input int s, input logic [4:0] rd, input logic [31:0] d, input logic [TW-1:0] t);
    in_v[s] = 1; in_rd[s] = rd; in_data[s] = d; in_tag[s] = t;
  endtask

  initial begin
    int p0;
    for (int s = 0; s < 4; s++) begin
      in_v[s] = 0; in_rd[s] = '0; in_data[s] = '0; in_tag[s] = '0;
    end
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    chk("rst_ready", 64'(rdy), 64'hF);
    chk("rst_mask", 64'(mask), 64'h0);
    chk("rst_wr_en", 64'(exu_en), 64'h0);
    step();

    // Single ALU result: write pulse two cycles later.
    p0 = pulses;
    drive(0, 5'd5, 32'h1234, 8'd3);
    step();
    drain(4);
    chk("alu_single_pulses", 64'(pulses - p0), 64'd1);

    // ALU, MUL and LSU together.
    drive(0, 5'd1, 32'hA1, 8'h11);
    drive(1, 5'd2, 32'hB2, 8'h22);
    drive(3, 5'd3, 32'hC3, 8'h33);
    step();
    drain(5);

    // All four sources kept busy.
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < 4; s++)
        if (!in_v[s] || acc[s]) drive(s, 5'(8 + s), $urandom, 8'(i * 4 + s));
      step();
    end
    drain(8);

    // rd = x0 is swallowed.
    p0 = pulses;
    drive(3, 5'd0, 32'hDEAD, 8'h44);
    step();
    drain(3);
    chk("rd0_pulses", 64'(pulses - p0), 64'd0);

    // MUL streaming every cycle.
    p0 = pulses;
    mul_drop = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(7 + i), $urandom, 8'(i));
      step();
    end
    drain(3);
    chk("mul_stream_pulses", 64'(pulses - p0), 64'd10);
    chk("mul_stream_ready_drop", 64'(mul_drop), 64'd0);

    // Reset while buffers are full.
    drive(0, 5'd20, 32'h20, 8'h20);
    drive(1, 5'd21, 32'h21, 8'h21);
    drive(2, 5'd22, 32'h22, 8'h22);
    step();
    for (int s = 0; s < 4; s++) in_v[s] = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 64'(exu_en), 64'h0);
    chk("arst_rd", 64'(exu_rd), 64'h0);
    chk("arst_data", 64'(exu_data), 64'h0);
    chk("arst_tag", 64'(exu_tag), 64'h0);
    chk("arst_mask", 64'(mask), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_ready", 64'(rdy), 64'hF);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    p0 = pulses;
    drain(4);
    chk("arst_no_wb", 64'(pulses - p0), 64'd0);

    // Random traffic honouring hold-until-ready.
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 4; s++) begin
        if (!(in_v[s] && !acc[s])) begin
          in_v[s]    = ($urandom_range(0, 99) < 45);
          in_rd[s]   = 5'($urandom_range(0, 31));
          in_data[s] = $urandom;
          in_tag[s]  = 8'($urandom);
        end
      end
      step();
    end
    drain(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
